// File: rtl/cpu_pkg.sv
// Shared CPU constants: default word width, the NOP encoding and the
// program-memory load/run state type.
package cpu_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/prog_mem_rdpipe.sv
// Fixed-latency fetch response pipeline carrying valid/inst/err, with a
// synchronous flush that squashes every in-flight response.
module prog_mem_rdpipe #(
   parameter int unsigned W   = 32,
   parameter int unsigned LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_inst,
   input  logic         in_err,
   output logic         out_valid,
   output logic [W-1:0] out_inst,
   output logic         out_err
);

   logic [LAT-1:0] valid_q;
   logic [LAT-1:0] err_q;
   logic [W-1:0]   inst_q [LAT];

   // Shift register; the producer zeroes inst/err for idle slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < int'(LAT); i++) inst_q[i] <= '0;
      end else if (flush) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < int'(LAT); i++) inst_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         err_q[0]   <= in_err;
         inst_q[0]  <= in_inst;
         for (int i = 1; i < int'(LAT); i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            inst_q[i]  <= inst_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_err   = err_q[LAT-1];
   assign out_inst  = inst_q[LAT-1];

endmodule

// File: rtl/prog_mem.sv
// Instruction memory filled by a streaming loader, then serving pipelined
// fetches with fixed latency; reload restarts loading and squashes fetches.
module prog_mem
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ld_valid,
   input  logic [XLEN-1:0]        ld_data,
   input  logic                   ld_last,
   output logic                   ld_ready,
   input  logic                   reload,
   output logic                   load_done,
   output logic [$clog2(DEPTH):0] word_count,
   input  logic                   fetch_req,
   input  logic [31:0]            fetch_addr,
   output logic                   fetch_valid,
   output logic [XLEN-1:0]        fetch_inst,
   output logic                   fetch_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_e          state_q;
   logic [CW-1:0]   count_q;
   logic            ld_ready_q;
   logic            load_done_q;
   logic [XLEN-1:0] mem [DEPTH];

   logic            ld_accept_c;
   logic            fetch_accept_c;
   logic [29:0]     idx_c;
   logic            misal_c;
   logic            oob_c;
   logic            hit_c;
   logic [XLEN-1:0] inst_c;
   logic            err_c;

   // reload has priority over both loader words and fetches
   assign ld_accept_c    = (state_q == LOAD) && ld_valid && !reload;
   assign fetch_accept_c = (state_q == RUN) && fetch_req && !reload;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         count_q     <= '0;
         ld_ready_q  <= 1'b1;
         load_done_q <= 1'b0;
      end else if (reload) begin
         state_q     <= LOAD;
         count_q     <= '0;
         ld_ready_q  <= 1'b1;
         load_done_q <= 1'b0;
      end else if (ld_accept_c) begin
         count_q <= count_q + CW'(1);
         if (ld_last || (count_q == CW'(DEPTH - 1))) begin
            state_q     <= RUN;
            ld_ready_q  <= 1'b0;
            load_done_q <= 1'b1;
         end
      end
   end

   // Storage is not reset; stale words stay hidden behind count_q.
   always_ff @(posedge clk) begin
      if (ld_accept_c) mem[count_q[AW-1:0]] <= ld_data;
   end

   assign idx_c   = fetch_addr[31:2];
   assign misal_c = |fetch_addr[1:0];
   assign oob_c   = idx_c >= 30'(DEPTH);
   assign hit_c   = idx_c < 30'(count_q);

   always_comb begin
      inst_c = '0;
      err_c  = 1'b0;
      if (fetch_accept_c) begin
         if (misal_c || oob_c) begin
            inst_c = XLEN'(NOP);
            err_c  = 1'b1;
         end else if (hit_c) begin
            inst_c = mem[idx_c[AW-1:0]];
         end else begin
            inst_c = XLEN'(NOP);
         end
      end
   end

   prog_mem_rdpipe #(
      .W   (XLEN),
      .LAT (RD_LAT)
   ) u_rdpipe (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (reload),
      .in_valid  (fetch_accept_c),
      .in_inst   (inst_c),
      .in_err    (err_c),
      .out_valid (fetch_valid),
      .out_inst  (fetch_inst),
      .out_err   (fetch_err)
   );

   assign ld_ready   = ld_ready_q;
   assign load_done  = load_done_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_prog_mem.sv
// Randomized bench for prog_mem against a queue-based program/fetch model.
module tb_prog_mem;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOPW   = 32'h0000_0013;

   logic            clk;
   logic            reset;
   logic            ld_valid;
   logic [XLEN-1:0] ld_data;
   logic            ld_last;
   logic            ld_ready;
   logic            reload;
   logic            load_done;
   logic [CW-1:0]   word_count;
   logic            fetch_req;
   logic [31:0]     fetch_addr;
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_inst;
   logic            fetch_err;

   prog_mem #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .reload      (reload),
      .load_done   (load_done),
      .word_count  (word_count),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_inst  (fetch_inst),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          rem;
      logic [31:0] inst;
      logic        err;
   } item_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] m_mem [DEPTH];
   int          m_count  = 0;
   bit          m_run    = 0;
   item_t       pend [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic item_t expect_fetch(input logic [31:0] a);
      item_t       it;
      int unsigned idx;
      idx    = int'(a[31:2]);
      it.rem = RD_LAT - 1;
      if (a[1:0] != 2'b00 || idx >= DEPTH) begin
         it.inst = NOPW;
         it.err  = 1'b1;
      end else if (idx < m_count) begin
         it.inst = m_mem[idx];
         it.err  = 1'b0;
      end else begin
         it.inst = NOPW;
         it.err  = 1'b0;
      end
      return it;
   endfunction

   task automatic model_reset();
      m_run   = 0;
      m_count = 0;
      pend.delete();
   endtask

   task automatic check_outputs();
      bit          ev = 0;
      logic [31:0] ei = '0;
      logic        ee = 1'b0;
      if (pend.size() > 0 && pend[0].rem == 0) begin
         ev = 1;
         ei = pend[0].inst;
         ee = pend[0].err;
         void'(pend.pop_front());
      end
      check("ld_ready", 64'(ld_ready), 64'(!m_run));
      check("load_done", 64'(load_done), 64'(m_run));
      check("word_count", 64'(word_count), 64'(m_count));
      check("fetch_valid", 64'(fetch_valid), 64'(ev));
      check("fetch_inst", 64'(fetch_inst), 64'(ei));
      check("fetch_err", 64'(fetch_err), 64'(ee));
   endtask

   // Drive one cycle, advance the model across the edge, then compare.
   task automatic step(input logic lv, input logic [31:0] ld, input logic ll,
                       input logic rl, input logic fr, input logic [31:0] fa);
      ld_valid   = lv;
      ld_data    = ld;
      ld_last    = ll;
      reload     = rl;
      fetch_req  = fr;
      fetch_addr = fa;
      for (int i = 0; i < pend.size(); i++) pend[i].rem = pend[i].rem - 1;
      if (rl) begin
         model_reset();
      end else if (!m_run) begin
         if (lv) begin
            m_mem[m_count] = ld;
            m_count++;
            if (ll || m_count == DEPTH) m_run = 1;
         end
      end else if (fr) begin
         pend.push_back(expect_fetch(fa));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic fetch(input logic [31:0] a);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'($urandom);
      if (r == 1) return 32'($urandom_range(0, DEPTH * 4 + 15));
      return 32'($urandom_range(0, DEPTH + 3)) << 2;
   endfunction

   task automatic async_reset_check();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset = 1'b1;
      idle(1);
   endtask

   initial begin
      reset      = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;
      reload     = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      repeat (2) @(negedge clk);
      check_outputs();
      reset = 1'b1;
      idle(1);

      // eight-word program, last flag on the eighth word
      for (int i = 0; i < 8; i++)
         step(1'b1, (i == 0) ? 32'h0020_80B3 : 32'($urandom), i == 7, 1'b0, 1'b0, '0);
      check("count_after_load", 64'(word_count), 64'd8);
      check("done_after_load", 64'(load_done), 64'd1);

      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h1C);
      idle(3);
      fetch(32'h20);
      fetch(32'h2);
      fetch(32'(DEPTH * 4));
      idle(3);
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, 1'b0, 1'($urandom), rand_addr());
      idle(3);

      // reload with fetches in flight and one in the reload cycle
      fetch(32'h0);
      fetch(32'h4);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h8);
      idle(4);

      // reload while still loading
      for (int i = 0; i < 3; i++) step(1'b1, 32'($urandom), 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      check("count_after_reload", 64'(word_count), 64'd0);

      // capacity fill without ld_last
      for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b1, 32'($urandom), 1'b0, 1'b0, 1'b0, '0);
      check("count_full", 64'(word_count), 64'(DEPTH));
      check("ready_full", 64'(ld_ready), 64'd0);
      for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, rand_addr());
      idle(3);

      // mixed random traffic
      for (int i = 0; i < 500; i++)
         step(1'($urandom), 32'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 39) == 0), 1'($urandom), rand_addr());
      idle(3);

      // asynchronous reset mid-load
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'($urandom), 1'b0, 1'b0, 1'b0, '0);
      async_reset_check();

      // asynchronous reset with fetches in flight
      for (int i = 0; i < 4; i++) step(1'b1, 32'($urandom), i == 3, 1'b0, 1'b0, '0);
      fetch(32'h0);
      fetch(32'h4);
      async_reset_check();
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
